vga_draw_arbiter: RTL
=====================

VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 Parameter X_W, default 8, VGA x-coordinate width.
REQ-002 Parameter Y_W, default 7, VGA y-coordinate width.
REQ-003 Parameter C_W, default 3, colour width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  3  per-requester draw request, bit 0 = clear, bit 1 = snake, bit 2 = food.
REQ-008 x_in  in  3*X_W  packed block x-origin, requester i at bits [i*X_W +: X_W].
REQ-009 y_in  in  3*Y_W  packed block y-origin, same packing.
REQ-010 colour_in  in  3*C_W  packed block colour, same packing.
REQ-011 grant  out  3  one-hot owner of the VGA port; all zeros when idle.
REQ-012 done  out  3  one-cycle completion pulse to the owner.
REQ-013 vga_x  out  X_W  plot x to the VGA adapter.
REQ-014 vga_y  out  Y_W  plot y to the VGA adapter.
REQ-015 vga_colour  out  C_W  plot colour.
REQ-016 vga_plot  out  1  plot strobe.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-019 IDLE: on an edge with req != 0, pick a winner, latch its x/y/colour, set grant[winner] and drawCnt=0, go to DRAW; with req == 0, stay in IDLE.
REQ-020 Winner selection SHALL be round-robin: search starts at (last+1) mod 3, and the first set req bit wins.
REQ-021 DRAW: vga_plot=1, vga_x = base_x + drawCnt[0], vga_y = base_y + drawCnt[1], vga_colour = latched colour.
REQ-022 DRAW SHALL increment drawCnt each cycle and, after drawCnt==3, go to DONE, giving exactly 4 plot cycles.
REQ-023 DONE: done[winner]=1 for one cycle, grant held, last := winner, go to IDLE.
REQ-024 grant SHALL clear on entry to IDLE.
REQ-025 Latency: with req sampled at edge k, plots occur in cycles k+1..k+4, done is in cycle k+5, and the earliest next grant is edge k+6.
REQ-026 Coordinate addition SHALL truncate to X_W/Y_W, wrapping modulo 2^width with no clamping.
REQ-027 req or inputs changing during DRAW/DONE SHALL be ignored; latched values are used and done is still pulsed.
REQ-028 A req still high after done SHALL count as a new request, arbitrated by round-robin in the next IDLE.
REQ-029 Outside DRAW, vga_plot=0 and vga_x/vga_y/vga_colour=0.
REQ-030 At most one grant bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-031 While rst=1, state SHALL be IDLE, and drawCnt, grant, done, vga_* and busy SHALL all be 0.
REQ-032 While rst=1, last SHALL be 2, so requester 0 wins first after reset.
REQ-033 Reset mid-DRAW SHALL abort the block immediately with no done pulse; the requester re-requests.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/DRAW/DONE) and NUM_REQ=3.
REQ-035 The shared package SHALL hold index constants REQ_CLEAR=0, REQ_SNAKE=1 and REQ_FOOD=2.
REQ-036 The round-robin picker SHALL be one sub-module, rr_pick3 (inputs: req[2:0], last[1:0]; outputs: winner[1:0], valid), purely combinational.

Verification
REQ-037 Single request: req=3'b010, snake x=10, y=20, colour=3'b010 -> plots (10,20),(11,20),(10,21),(11,21) with colour 3'b010, then done=3'b010 one cycle.
REQ-038 Simultaneous requests: req=3'b111 held after reset -> grant order 001, 010, 100, 001, one IDLE cycle between blocks.
REQ-039 Wrap: food x=255, y=127 -> plots (255,127),(0,127),(255,0),(0,0).
REQ-040 Mid-draw change: drop req and change x_in in DRAW cycle 2 -> all 4 plots use the latched origin, and done still pulses.
REQ-041 Reset mid-draw: assert rst in DRAW cycle 3 -> all outputs 0 immediately, no done; after release, req=3'b101 -> requester 0 granted first.

Source files
------------

// File: rtl/vga_draw_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter_pkg
// Shared definitions for the VGA draw arbiter: FSM state encoding, requester
// count, requester index constants and the round-robin wrap helper.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_draw_arbiter_pkg;

    localparam int NUM_REQ   = 3;

    // Requester indices into req/grant/done and the packed coordinate buses.
    localparam int REQ_CLEAR = 0;
    localparam int REQ_SNAKE = 1;
    localparam int REQ_FOOD  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    // Next requester index modulo NUM_REQ. The unused code 3 also maps to 0
    // so a corrupted index can never lock the arbiter.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter_if
// Bundles the requester-side handshake (req/grant/done with packed per-requester
// block origin and colour) and the VGA adapter plot port.
//   slave  : the arbiter (consumes requests, drives grant/done/vga_*/busy)
//   master : requesters / environment (drives requests, observes outputs)
// Parameters: X_W / Y_W coordinate widths, C_W colour width.
// -----------------------------------------------------------------------------
interface vga_draw_arbiter_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    import vga_draw_arbiter_pkg::*;

    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*X_W-1:0] x_in;
    logic [NUM_REQ*Y_W-1:0] y_in;
    logic [NUM_REQ*C_W-1:0] colour_in;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic [X_W-1:0]         vga_x;
    logic [Y_W-1:0]         vga_y;
    logic [C_W-1:0]         vga_colour;
    logic                   vga_plot;
    logic                   busy;

    modport slave (
        input  req, x_in, y_in, colour_in,
        output grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );

    modport master (
        output req, x_in, y_in, colour_in,
        input  grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );

endinterface

// File: rtl/vga_draw_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Purely combinational 3-way round-robin picker. The search starts at
// (last+1) mod 3 and the first asserted request bit wins.
//   req[2:0]    in   request vector
//   last[1:0]   in   previous winner
//   winner[1:0] out  selected requester (0 when valid is low)
//   valid       out  at least one request is set
// -----------------------------------------------------------------------------
module rr_pick3
    import vga_draw_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] cand0, cand1, cand2;

    // Candidates in search order, highest priority first.
    assign cand0 = rr_next(last);
    assign cand1 = rr_next(cand0);
    assign cand2 = rr_next(cand1);

    assign valid = |req;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        winner = 2'd0;
        if (req[cand0])      winner = cand0;
        else if (req[cand1]) winner = cand1;
        else if (req[cand2]) winner = cand2;
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter
// Shares one VGA adapter plot port between three requesters (clear, snake,
// food). The winner's block origin and colour are latched and a 2x2 block is
// plotted over four cycles, followed by a one-cycle done pulse to the owner.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  vga_draw_arbiter_if.slave: req/x_in/y_in/colour_in in,
//        grant/done/vga_x/vga_y/vga_colour/vga_plot/busy out
// -----------------------------------------------------------------------------
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    vga_draw_arbiter_if.slave   bus
);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         winner_q, winner_d;
    logic [X_W-1:0]     base_x_q, base_x_d;
    logic [Y_W-1:0]     base_y_q, base_y_d;
    logic [C_W-1:0]     colour_q, colour_d;

    logic [1:0]         pick_winner;
    logic               pick_valid;

    rr_pick3 u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            grant_q  <= '0;
            last_q   <= 2'd2;   // requester 0 is searched first after reset
            winner_q <= 2'd0;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
        end
    end

    // Next-state logic. Requests and inputs are only looked at in IDLE, so
    // anything that changes during DRAW/DONE has no effect on the block.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        winner_d = winner_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        colour_d = colour_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d              = DRAW;
                    cnt_d                = 2'd0;
                    winner_d             = pick_winner;
                    grant_d              = '0;
                    grant_d[pick_winner] = 1'b1;
                    base_x_d             = bus.x_in[pick_winner*X_W +: X_W];
                    base_y_d             = bus.y_in[pick_winner*Y_W +: Y_W];
                    colour_d             = bus.colour_in[pick_winner*C_W +: C_W];
                end
            end
            DRAW: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = winner_q;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs are decoded from registered state only; in DRAW the low count
    // bit steps x and the high bit steps y, giving the 2x2 block. The sums
    // truncate to the coordinate width, so the block wraps at the edges.
    always_comb begin
        bus.vga_plot   = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.done       = '0;
        if (state_q == DRAW) begin
            bus.vga_plot   = 1'b1;
            bus.vga_x      = base_x_q + X_W'(cnt_q[0]);
            bus.vga_y      = base_y_q + Y_W'(cnt_q[1]);
            bus.vga_colour = colour_q;
        end
        if (state_q == DONE) begin
            bus.done = grant_q;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
